tsense_alarm: RTL
=================

// Module: tsense_alarm
// PURPOSE
//   Post-processing stage downstream of the LM07 SPI read controller. Consumes each
//   8-bit temperature byte as the reader publishes it, keeps a moving average over
//   the last 2^AVG_LOG2 samples, tracks running min/max, and drives an over-temp
//   alarm with hysteresis and a consecutive-trip filter.
// PARAMETERS
//   AVG_LOG2   2      log2 of averaging window (window N = 4); legal 1..4
//   TH_HI      40     signed 8-bit trip threshold (alarm candidate when avg > TH_HI)
//   TH_LO      35     signed 8-bit release threshold (alarm clears when avg < TH_LO); TH_LO <= TH_HI
//   TRIP_CNT   3      consecutive averaged samples above TH_HI needed to alarm; >= 1
// PORTS
//   SYSCLK       in   1  system clock, all state on rising edge
//   RSTN         in   1  asynchronous active-low reset
//   sample_valid in   1  one-cycle strobe: sample holds a new reading
//   sample       in   8  signed two's-complement temperature byte (reader outreg)
//   clr_minmax   in   1  one-cycle strobe: restart min/max tracking
//   avg          out  8  signed moving average
//   avg_valid    out  1  high once window has been filled since reset
//   avg_upd      out  1  one-cycle pulse when avg was just updated
//   tmax         out  8  signed maximum raw sample since reset/clear
//   tmin         out  8  signed minimum raw sample since reset/clear
//   alarm_state  out  2  FSM state: 0 NORMAL, 1 PENDING, 2 ALARM
//   alarm        out  1  registered, high iff alarm_state == ALARM
// BEHAVIOUR
//   Reset (async, RSTN low, any time incl. mid-operation): buffer, sum, write pointer,
//     fill count, trip count = 0; avg=0, avg_valid=0, avg_upd=0, alarm_state=NORMAL,
//     alarm=0, tmax=8'h80 (-128), tmin=8'h7F (+127).
//   Averaging: N-entry circular buffer, signed running sum of width 8+AVG_LOG2.
//     On sample_valid (cycle n): sum <= sum + sample - buf[wptr]; buf[wptr] <= sample;
//     wptr increments modulo N; fill count saturates at N.
//     Cycle n+1: avg = sum >>> AVG_LOG2 (arithmetic shift, rounds toward -inf),
//     avg_upd pulses; avg_valid rises with the update for the Nth sample, stays high.
//   sample_valid on consecutive cycles is legal; every strobe is accepted, none dropped.
//   Alarm FSM: evaluated only on avg_upd with avg_valid=1; state/alarm change at n+2.
//     NORMAL : avg > TH_HI -> PENDING, tcnt=1 (TRIP_CNT==1 -> ALARM directly).
//     PENDING: avg > TH_HI -> tcnt++; tcnt reaching TRIP_CNT -> ALARM;
//              avg <= TH_HI -> NORMAL, tcnt=0.
//     ALARM  : avg < TH_LO -> NORMAL, tcnt=0; otherwise hold (avg == TH_LO holds).
//     Comparisons signed. State 3 unreachable; if entered, recover to NORMAL next cycle.
//   Min/max: on sample_valid, signed compare of raw sample; update at n+1.
//     clr_minmax alone -> tmax=8'h80, tmin=8'h7F. clr_minmax with sample_valid in same
//     cycle -> tmax=tmin=sample. clr_minmax does not affect averaging or alarm.
// TESTING
//   1 Reset: RSTN=0 -> avg=0, avg_valid=0, alarm=0, alarm_state=0, tmax=8'h80, tmin=8'h7F;
//     reassert RSTN mid-window after 2 samples -> all return to reset values immediately.
//   2 Fill: samples 20,20,20,20 -> avg_valid low until 4th; one cycle after 4th strobe
//     avg=20, avg_valid=1, avg_upd one-cycle pulse.
//   3 Signed math: samples -3,-3,-3,-2 -> sum=-11, avg=-3 (8'hFD); tmin=-3, tmax=-2.
//   4 Trip: six samples of 50 -> PENDING after 4th, tcnt 2 after 5th, alarm=1 two cycles
//     after 6th strobe; sequence 50x4 then 30x4 (pending aborts) -> no alarm.
//   5 Hysteresis: from ALARM with window of 50s, feed 36x4 -> avg 46,43,39,36, alarm held;
//     then 30 -> avg 34 < 35 -> alarm=0, alarm_state=NORMAL.
//   6 Min/max: samples 10,-5,60 -> tmax=60, tmin=-5; clr_minmax with sample 7 in same
//     cycle -> tmax=tmin=7; back-to-back strobes every cycle -> no sample lost.

Source files
------------

// File: rtl/tsense_alarm.sv
// Temperature post-processing: moving average, running min/max and an over-temp
// alarm FSM with hysteresis and a consecutive-trip filter.
module tsense_alarm #(
    parameter int               AVG_LOG2 = 2,
    parameter logic signed [7:0] TH_HI   = 8'sd40,
    parameter logic signed [7:0] TH_LO   = 8'sd35,
    parameter int               TRIP_CNT = 3
) (
    input  logic       SYSCLK,
    input  logic       RSTN,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    input  logic       clr_minmax,
    output logic [7:0] avg,
    output logic       avg_valid,
    output logic       avg_upd,
    output logic [7:0] tmax,
    output logic [7:0] tmin,
    output logic [1:0] alarm_state,
    output logic       alarm
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 8 + AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TRIP_CNT + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [TW-1:0] TRIP_W    = TW'(TRIP_CNT);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALARM   = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    function automatic logic signed [SW-1:0] sext8(input logic [7:0] v);
        return {{(SW-8){v[7]}}, v};
    endfunction

    logic [7:0]          smp_buf_q [N];
    logic signed [SW-1:0] sum_q, sum_d, new_sum_s, shifted_s;
    logic [AVG_LOG2-1:0] wptr_q, wptr_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [7:0]          avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                avg_upd_q, avg_upd_d;
    logic [7:0]          tmax_q, tmax_d, tmin_q, tmin_d;
    state_t              state_q, state_d;
    logic [TW-1:0]       tcnt_q, tcnt_d, tcnt_inc_s;
    logic                alarm_q, alarm_d;
    logic                eval_s, above_hi_s, below_lo_s;

    // Running-sum averaging datapath; the new average is published the cycle after the strobe.
    always_comb begin
        new_sum_s   = sum_q + sext8(sample) - sext8(smp_buf_q[wptr_q]);
        shifted_s   = new_sum_s >>> AVG_LOG2;
        sum_d       = sum_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;
        avg_upd_d   = 1'b0;
        if (sample_valid) begin
            sum_d     = new_sum_s;
            wptr_d    = wptr_q + AVG_LOG2'(1'b1);
            if (fill_q == FILL_FULL) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FW'(1'b1);
            end
            avg_d       = shifted_s[7:0];
            avg_upd_d   = 1'b1;
            avg_valid_d = avg_valid_q | (fill_d == FILL_FULL);
        end else begin
            avg_upd_d = 1'b0;
        end
    end

    // Min/max tracking; a clear coinciding with a sample seeds both trackers with that sample.
    always_comb begin
        tmax_d = tmax_q;
        tmin_d = tmin_q;
        if (sample_valid && clr_minmax) begin
            tmax_d = sample;
            tmin_d = sample;
        end else if (clr_minmax) begin
            tmax_d = 8'h80;
            tmin_d = 8'h7F;
        end else if (sample_valid) begin
            if ($signed(sample) > $signed(tmax_q)) begin
                tmax_d = sample;
            end else begin
                tmax_d = tmax_q;
            end
            if ($signed(sample) < $signed(tmin_q)) begin
                tmin_d = sample;
            end else begin
                tmin_d = tmin_q;
            end
        end else begin
            tmax_d = tmax_q;
            tmin_d = tmin_q;
        end
    end

    // Alarm FSM next state; only a fresh, fully-windowed average is evaluated.
    always_comb begin
        eval_s     = avg_upd_q & avg_valid_q;
        above_hi_s = $signed(avg_q) > TH_HI;
        below_lo_s = $signed(avg_q) < TH_LO;
        tcnt_inc_s = tcnt_q + TW'(1'b1);
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (eval_s && above_hi_s) begin
                    tcnt_d  = TW'(1'b1);
                    state_d = (TRIP_CNT == 1) ? ST_ALARM : ST_PENDING;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_PENDING: begin
                if (eval_s && above_hi_s) begin
                    tcnt_d  = tcnt_inc_s;
                    state_d = (tcnt_inc_s >= TRIP_W) ? ST_ALARM : ST_PENDING;
                end else if (eval_s) begin
                    tcnt_d  = TW'(1'b0);
                    state_d = ST_NORMAL;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_ALARM: begin
                if (eval_s && below_lo_s) begin
                    tcnt_d  = TW'(1'b0);
                    state_d = ST_NORMAL;
                end else begin
                    state_d = ST_ALARM;
                end
            end
            default: begin
                tcnt_d  = TW'(1'b0);
                state_d = ST_NORMAL;
            end
        endcase
        alarm_d = (state_d == ST_ALARM);
    end

    // State registers.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < N; i++) begin
                smp_buf_q[i] <= 8'h00;
            end
            sum_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            avg_q       <= 8'h00;
            avg_valid_q <= 1'b0;
            avg_upd_q   <= 1'b0;
            tmax_q      <= 8'h80;
            tmin_q      <= 8'h7F;
            state_q     <= ST_NORMAL;
            tcnt_q      <= '0;
            alarm_q     <= 1'b0;
        end else begin
            if (sample_valid) begin
                smp_buf_q[wptr_q] <= sample;
            end
            sum_q       <= sum_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            avg_upd_q   <= avg_upd_d;
            tmax_q      <= tmax_d;
            tmin_q      <= tmin_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            alarm_q     <= alarm_d;
        end
    end

    assign avg         = avg_q;
    assign avg_valid   = avg_valid_q;
    assign avg_upd     = avg_upd_q;
    assign tmax        = tmax_q;
    assign tmin        = tmin_q;
    assign alarm_state = state_q;
    assign alarm       = alarm_q;
endmodule
